// File: rtl/pkt_source_tx.sv
// Purpose : buffers up to 63 payload bytes, then emits header, payload and parity toward the router.
// Latency : start -> header on data_out in 1 cycle; N-byte packet occupies N+2 cycles with busy low.
// Backpressure: busy=1 holds data_out/pkt_valid and the packet position; nothing is dropped.
//
// Ports:
//   clk, resetn (synchronous, active-high)
//   wr_en/wr_data : payload byte load (IDLE only)
//   start/addr    : launch packet to port addr (0..2)
//   busy          : router backpressure
//   pkt_valid/data_out : byte stream toward router
//   ready, buf_cnt, done, cmd_err : status
// Optional feature: define PKT_SOURCE_ERR_INJECT_EN to add input inj_err, which inverts
// the parity byte of the packet it is latched with.
module pkt_source_tx (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [1:0] addr,
  input  logic       busy,
`ifdef PKT_SOURCE_ERR_INJECT_EN
  input  logic       inj_err,
`endif
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       ready,
  output logic [5:0] buf_cnt,
  output logic       done,
  output logic       cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PLD, S_PAR} state_t;

  state_t     state_q, state_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic [7:0] data_out_q, data_out_d;
  logic       ready_q, ready_d;
  logic [5:0] buf_cnt_q, buf_cnt_d;
  logic       done_q, done_d;
  logic       cmd_err_q, cmd_err_d;
  logic [5:0] idx_q, idx_d;      // index of the payload byte currently on data_out
  logic [7:0] par_q, par_d;      // running XOR of bytes already accepted
  logic [7:0] par_flip;

  logic [7:0] mem_q [64];

  logic start_ok;
  logic wr_ok;
  logic last_byte;

  // buf_cnt cannot change outside IDLE, so it doubles as the packet length.
  assign start_ok  = start && (addr != 2'd3) && (buf_cnt_q != 6'd0);
  assign wr_ok     = wr_en && (state_q == S_IDLE) && !start && (buf_cnt_q != 6'd63);
  assign last_byte = (idx_q == (buf_cnt_q - 6'd1));

`ifdef PKT_SOURCE_ERR_INJECT_EN
  logic inj_q, inj_d;
  assign par_flip = {8{inj_q}};
`else
  assign par_flip = 8'h00;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (resetn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok)            state_d = S_HDR;
      S_HDR:  if (!busy)               state_d = S_PLD;
      S_PLD:  if (!busy && last_byte)  state_d = S_PAR;
      S_PAR:  if (!busy)               state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    pkt_valid_d = pkt_valid_q;
    data_out_d  = data_out_q;
    buf_cnt_d   = buf_cnt_q;
    idx_d       = idx_q;
    par_d       = par_q;
    done_d      = 1'b0;
    ready_d     = (state_d == S_IDLE);
`ifdef PKT_SOURCE_ERR_INJECT_EN
    inj_d       = inj_q;
`endif
    // Any dropped write and any rejected launch in IDLE is flagged.
    cmd_err_d   = (wr_en && !wr_ok) || ((state_q == S_IDLE) && start && !start_ok);

    if (wr_ok) buf_cnt_d = buf_cnt_q + 6'd1;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          pkt_valid_d = 1'b1;
          data_out_d  = {buf_cnt_q, addr};
          par_d       = {buf_cnt_q, addr};
          idx_d       = 6'd0;
`ifdef PKT_SOURCE_ERR_INJECT_EN
          inj_d       = inj_err;
`endif
        end
      end
      S_HDR: begin
        if (!busy) begin
          data_out_d = mem_q[6'd0];
          idx_d      = 6'd0;
        end
      end
      S_PLD: begin
        if (!busy) begin
          par_d = par_q ^ data_out_q;
          if (last_byte) begin
            pkt_valid_d = 1'b0;
            data_out_d  = par_q ^ data_out_q ^ par_flip;
          end else begin
            idx_d      = idx_q + 6'd1;
            data_out_d = mem_q[idx_q + 6'd1];
          end
        end
      end
      S_PAR: begin
        if (!busy) begin
          pkt_valid_d = 1'b0;
          data_out_d  = 8'h00;
          buf_cnt_d   = 6'd0;
          done_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      pkt_valid_q <= 1'b0;
      data_out_q  <= 8'h00;
      ready_q     <= 1'b1;
      buf_cnt_q   <= 6'd0;
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      idx_q       <= 6'd0;
      par_q       <= 8'h00;
`ifdef PKT_SOURCE_ERR_INJECT_EN
      inj_q       <= 1'b0;
`endif
    end else begin
      pkt_valid_q <= pkt_valid_d;
      data_out_q  <= data_out_d;
      ready_q     <= ready_d;
      buf_cnt_q   <= buf_cnt_d;
      done_q      <= done_d;
      cmd_err_q   <= cmd_err_d;
      idx_q       <= idx_d;
      par_q       <= par_d;
`ifdef PKT_SOURCE_ERR_INJECT_EN
      inj_q       <= inj_d;
`endif
    end
  end

  // Payload storage is never cleared; only buf_cnt decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[buf_cnt_q] <= wr_data;
  end

  assign pkt_valid = pkt_valid_q;
  assign data_out  = data_out_q;
  assign ready     = ready_q;
  assign buf_cnt   = buf_cnt_q;
  assign done      = done_q;
  assign cmd_err   = cmd_err_q;

endmodule
